// File: rtl/up_counter_ctrl.sv
// Button-driven run/pause/idle controller for a downstream counter.
// Synchronises and edge-detects three push-buttons, then produces a prescaled enable strobe and a clear pulse.
module up_counter_ctrl #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             clear_btn,
    input  logic [DIV_W-1:0] div,
    output logic             enable,
    output logic             clr,
    output logic             running
);

    localparam int NB = 3;
    localparam int REQ_START = 0;
    localparam int REQ_STOP  = 1;
    localparam int REQ_CLEAR = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] req;

    assign btn_raw = {clear_btn, stop_btn, start_btn};

    // One synchroniser plus rising-edge detector per button; a held button yields a single request.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   prev_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                    prev_q <= 1'b0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
                    prev_q <= sync_q[SYNC_STAGES-1];
                end
            end

            assign req[gi] = sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    endgenerate

    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             enable_q, enable_d;
    logic             clr_q, clr_d;
    logic             running_q, running_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            enable_q  <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            enable_q  <= enable_d;
            clr_q     <= clr_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        enable_d = 1'b0;
        clr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req[REQ_CLEAR]) begin
                    clr_d   = 1'b1;
                    presc_d = '0;
                end else if (req[REQ_START]) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                if (req[REQ_CLEAR]) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    presc_d = '0;
                end else if (req[REQ_STOP]) begin
                    state_d = ST_PAUSE;
                end else if (presc_q >= div) begin
                    // >= so a div lowered below the current count wraps immediately.
                    enable_d = 1'b1;
                    presc_d  = '0;
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            ST_PAUSE: begin
                if (req[REQ_CLEAR]) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    presc_d = '0;
                end else if (req[REQ_START]) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    assign enable  = enable_q;
    assign clr     = clr_q;
    assign running = running_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Randomised scoreboard bench for up_counter_ctrl: a behavioural model queues the expected outputs
// after every clock edge and a negedge monitor compares them with the DUT.
module tb_up_counter_ctrl;

    localparam int DIV_W = 16;
    localparam int S     = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start_btn = 1'b0;
    logic             stop_btn = 1'b0;
    logic             clear_btn = 1'b0;
    logic [DIV_W-1:0] div = 16'd3;
    logic             enable;
    logic             clr;
    logic             running;

    int total = 0;
    int bad   = 0;
    bit stim_done = 1'b0;

    logic [2:0] exp_q[$];

    up_counter_ctrl #(.DIV_W(DIV_W), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_btn(start_btn),
        .stop_btn (stop_btn),
        .clear_btn(clear_btn),
        .div      (div),
        .enable   (enable),
        .clr      (clr),
        .running  (running)
    );

    always #5 clk = ~clk;

    // Reference model: button history arrays give requests S edges late; mode 0=idle 1=run 2=pause.
    initial begin
        bit hs[1:S+1];
        bit hp[1:S+1];
        bit hc[1:S+1];
        int mode;
        int presc;
        bit rs, rp, rc, e, c;
        mode  = 0;
        presc = 0;
        for (int k = 1; k <= S + 1; k++) begin
            hs[k] = 1'b0; hp[k] = 1'b0; hc[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            e = 1'b0;
            c = 1'b0;
            if (reset) begin
                for (int k = 1; k <= S + 1; k++) begin
                    hs[k] = 1'b0; hp[k] = 1'b0; hc[k] = 1'b0;
                end
                mode  = 0;
                presc = 0;
            end else begin
                rs = hs[S] && !hs[S+1];
                rp = hp[S] && !hp[S+1];
                rc = hc[S] && !hc[S+1];
                for (int k = S + 1; k >= 2; k--) begin
                    hs[k] = hs[k-1]; hp[k] = hp[k-1]; hc[k] = hc[k-1];
                end
                hs[1] = start_btn;
                hp[1] = stop_btn;
                hc[1] = clear_btn;
                if (rc) begin
                    mode  = 0;
                    presc = 0;
                    c     = 1'b1;
                end else if (rp && mode == 1) begin
                    mode = 2;
                end else if (rs && mode != 1) begin
                    if (mode == 0) presc = 0;
                    mode = 1;
                end else if (mode == 1) begin
                    if (presc >= int'(div)) begin
                        e     = 1'b1;
                        presc = 0;
                    end else begin
                        presc = presc + 1;
                    end
                end
            end
            exp_q.push_back({e, c, (mode == 1)});
        end
    end

    // Monitor: one comparison per cycle for the output triple, plus the enable/clr exclusion rule.
    initial begin
        logic [2:0] exp_v;
        logic [2:0] got_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {enable, clr, running};
                total++;
                if (got_v !== exp_v) begin
                    bad++;
                    $display("FAIL outputs t=%0t {enable,clr,running} got=%b exp=%b", $time, got_v, exp_v);
                end
                total++;
                if ((enable & clr) !== 1'b0) begin
                    bad++;
                    $display("FAIL excl t=%0t enable&clr got=%b exp=0", $time, enable & clr);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int which, input int len);
        if (which == 0) start_btn = 1'b1;
        if (which == 1) stop_btn  = 1'b1;
        if (which == 2) clear_btn = 1'b1;
        tick(len);
        if (which == 0) start_btn = 1'b0;
        if (which == 1) stop_btn  = 1'b0;
        if (which == 2) clear_btn = 1'b0;
    endtask

    initial begin
        int n;
        tick(3);
        reset = 1'b0;
        tick(2);

        // start with div=3: four-cycle strobe
        div = 16'd3;
        press(0, 1);
        tick(20);
        press(1, 1);
        tick(5);

        // div=0: continuous enable, then stop and clear
        div = 16'd0;
        press(0, 1);
        tick(10);
        press(1, 1);
        tick(5);
        press(2, 1);
        tick(5);

        // pause mid-period with div=4, then resume
        div = 16'd4;
        press(0, 1);
        tick(7);
        press(1, 1);
        tick(6);
        press(0, 1);
        tick(12);

        // simultaneous start/stop/clear while running
        start_btn = 1'b1; stop_btn = 1'b1; clear_btn = 1'b1;
        tick(1);
        start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0;
        tick(6);

        // held start gives one request; stop while still held, then release and re-press
        div = 16'd2;
        start_btn = 1'b1;
        tick(20);
        press(1, 1);
        tick(30);
        start_btn = 1'b0;
        tick(3);
        press(0, 1);
        tick(8);

        // reset mid-run with enable high, then a button held through reset release
        div = 16'd0;
        tick(3);
        reset = 1'b1;
        start_btn = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(6);
        start_btn = 1'b0;
        press(2, 1);
        tick(4);

        // lowering div below the running count wraps on the next compare
        div = 16'd7;
        press(0, 1);
        tick(8);
        div = 16'd2;
        tick(12);
        press(2, 1);
        tick(4);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 11) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(0, 19) == 0) clear_btn = ~clear_btn;
            if ($urandom_range(0, 49) == 0) div = DIV_W'($urandom_range(0, 6));
            reset = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        reset = 1'b0;
        start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0;
        tick(4);

        // bounded drain of the scoreboard
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d exp=0", exp_q.size());
        end
        total++;
        if (total < 100) begin
            bad++;
            $display("FAIL coverage comparisons got=%0d exp>=100", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
